c2_sched: RTL and testbench

Multi-cycle, resource-shared implementation of the c2 signed datapath. It takes operands on a start/done handshake and computes the same x and z results as the flat combinational-plus-register version. A single shared adder/subtractor and a single signed comparator are sequenced by an FSM. This trades area for 4-cycle latency and serves as the scheduled counterpart used in the HLS flow.

---
 rtl/c2_sched.sv | 146 ++++++++++++++
 tb/tb_c2_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/c2_sched.sv
// Resource-shared c2 signed datapath: one add/sub and one comparator sequenced
// over IDLE -> ADD1 -> ADD2 -> SUB -> OUT, giving 4-cycle latency per job.
module c2_sched #(
  parameter int DATAWIDTH = 32
) (
  input  logic                        Clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  output logic                        busy,
  output logic                        done,
  output logic signed [DATAWIDTH-1:0] x,
  output logic signed [DATAWIDTH-1:0] z
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD1 = 3'd1,
    ADD2 = 3'd2,
    SUB  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t                      state_r;
  logic signed [DATAWIDTH-1:0] ra_r, rb_r, rc_r;
  logic signed [DATAWIDTH-1:0] d_r, e_r, f_r;
  logic                        lt_r, eq_r;

  logic signed [DATAWIDTH-1:0] alu_b_s;
  logic                        alu_sub_s;
  logic signed [DATAWIDTH-1:0] alu_y_s;
  logic signed [DATAWIDTH-1:0] g_s, h_s, x_s, z_s;

  // Shared add/sub: second operand and op select depend on the current step.
  always_comb begin
    alu_b_s   = rb_r;
    alu_sub_s = 1'b0;
    case (state_r)
      ADD1: begin
        alu_b_s   = rb_r;
        alu_sub_s = 1'b0;
      end
      ADD2: begin
        alu_b_s   = rc_r;
        alu_sub_s = 1'b0;
      end
      SUB: begin
        alu_b_s   = rb_r;
        alu_sub_s = 1'b1;
      end
      default: begin
        alu_b_s   = rb_r;
        alu_sub_s = 1'b0;
      end
    endcase
    // Subtract as ra + ~rb + 1 so a single adder serves both operations.
    alu_y_s = ra_r + (alu_b_s ^ {DATAWIDTH{alu_sub_s}})
            + {{(DATAWIDTH-1){1'b0}}, alu_sub_s};
  end

  // Result selection and conditional shifts from the registered intermediates.
  always_comb begin
    if (lt_r) begin
      g_s = e_r;
    end else begin
      g_s = d_r;
    end
    if (eq_r) begin
      h_s = f_r;
    end else begin
      h_s = g_s;
    end
    if (lt_r) begin
      x_s = g_s << 1'b1;
    end else begin
      x_s = g_s;
    end
    if (eq_r) begin
      z_s = h_s >>> 1'b1;
    end else begin
      z_s = h_s;
    end
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      x       <= '0;
      z       <= '0;
      ra_r    <= '0;
      rb_r    <= '0;
      rc_r    <= '0;
      d_r     <= '0;
      e_r     <= '0;
      f_r     <= '0;
      lt_r    <= 1'b0;
      eq_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ra_r    <= a;
            rb_r    <= b;
            rc_r    <= c;
            busy    <= 1'b1;
            state_r <= ADD1;
          end else begin
            state_r <= IDLE;
          end
        end
        ADD1: begin
          d_r     <= alu_y_s;
          state_r <= ADD2;
        end
        ADD2: begin
          e_r     <= alu_y_s;
          state_r <= SUB;
        end
        SUB: begin
          f_r     <= alu_y_s;
          lt_r    <= (d_r < e_r);
          eq_r    <= (d_r == e_r);
          state_r <= OUT;
        end
        OUT: begin
          x       <= x_s;
          z       <= z_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2_sched.sv
// Directed and randomized bench for c2_sched against a behavioural model of the
// c2 function and the 4-cycle start/done handshake.
module tb_c2_sched;
  localparam int DW = 32;

  logic                 Clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [DW-1:0] a, b, c;
  logic                 busy, done;
  logic signed [DW-1:0] x, z;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [DW-1:0] prev_x, prev_z;

  always #5 Clk = ~Clk;

  c2_sched #(.DATAWIDTH(DW)) dut (
    .Clk  (Clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done),
    .x    (x),
    .z    (z)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic (int wraps mod 2^32), halving by floor division.
  function automatic void model(input int ma, input int mb, input int mc, output int xo, output int zo);
    int d, e, f, g, h;
    bit lt, eq;
    d  = ma + mb;
    e  = ma + mc;
    f  = ma - mb;
    lt = (d < e);
    eq = (d == e);
    g  = lt ? e : d;
    h  = eq ? f : g;
    xo = lt ? g * 2 : g;
    zo = eq ? (h - (h & 1)) / 2 : h;
  endfunction

  // Launch a job from the current (post-negedge) point and follow it to done.
  task automatic run_job(input int ja, input int jb, input int jc, input bit poke,
                         input bit direct, input int dx, input int dz);
    int ex, ez;
    if (direct) begin
      ex = dx;
      ez = dz;
    end else begin
      model(ja, jb, jc, ex, ez);
    end
    start = 1'b1;
    a = ja;
    b = jb;
    c = jc;
    @(posedge Clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      chk_bit("busy_inflight", busy, 1'b1);
      chk_bit("done_inflight", done, 1'b0);
      chk("x_hold", x, prev_x);
      chk("z_hold", z, prev_z);
      start = poke && (k < 4);
      a = $urandom;
      b = $urandom;
      c = $urandom;
    end
    @(negedge Clk);
    chk_bit("done_pulse", done, 1'b1);
    chk_bit("busy_at_done", busy, 1'b0);
    chk("x_result", x, ex);
    chk("z_result", z, ez);
    prev_x = ex;
    prev_z = ez;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      chk_bit("done_idle", done, 1'b0);
      chk_bit("busy_idle", busy, 1'b0);
      chk("x_idle", x, prev_x);
      chk("z_idle", z, prev_z);
    end
  endtask

  initial begin
    int ra, rb, rc, mode;
    rst   = 1'b0;
    start = 1'b1;
    a = 32'sd7;
    b = 32'sd7;
    c = 32'sd7;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk("rst_x", x, 32'h0);
    chk("rst_z", z, 32'h0);
    rst    = 1'b1;
    start  = 1'b0;
    prev_x = 32'h0;
    prev_z = 32'h0;
    idle(1);

    run_job(5, 3, 1, 1'b0, 1'b1, 8, 8);
    idle(1);
    run_job(1, 2, 5, 1'b0, 1'b1, 12, 6);
    idle(1);
    run_job(-10, 3, 3, 1'b0, 1'b1, -7, -7);
    idle(1);
    run_job(4, 2, 2, 1'b0, 1'b1, 6, 1);
    idle(1);
    run_job(32'h7FFFFFFF, 1, 0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF);
    idle(1);

    // Restarts while busy are ignored, then a back-to-back job from the done cycle.
    run_job(1, 2, 5, 1'b1, 1'b1, 12, 6);
    run_job(5, 3, 1, 1'b1, 1'b1, 8, 8);
    idle(1);

    // Abort a job while it sits in SUB.
    start = 1'b1;
    a = 100;
    b = 50;
    c = 25;
    @(posedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    rst = 1'b1;
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk("abort_x", x, 32'h0);
    chk("abort_z", z, 32'h0);
    prev_x = 32'h0;
    prev_z = 32'h0;
    idle(3);
    run_job(4, 2, 2, 1'b0, 1'b1, 6, 1);

    for (int j = 0; j < 40; j++) begin
      mode = $urandom_range(0, 2);
      ra = $urandom;
      rb = $urandom;
      rc = $urandom;
      if (mode == 1) begin
        rc = rb;
      end else if (mode == 2) begin
        ra = $urandom_range(0, 15) - 8;
        rb = $urandom_range(0, 15) - 8;
        rc = $urandom_range(0, 15) - 8;
      end
      run_job(ra, rb, rc, $urandom_range(0, 1) == 1, 1'b0, 0, 0);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
